vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Generates the raster scan that drives snake_game: pixel coordinates x/y, video_on, active-low hsync/vsync for a 640x480@60 Hz VGA display, and the frame-derived game_tick pulse that advances snake movement. It runs from the 100 MHz board clock using a pixel-enable divider, so the whole design shares one clock. It sits between the board clock and reset and snake_game; its hsync and vsync go to the VGA connector pins.

Parameters:
H_DISPLAY, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_DISPLAY, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
CLK_DIV, 4, clk_100MHz cycles per pixel (25 MHz pixel rate); must be at least 2
TICK_FRAMES, 6, frames per game_tick; must be at least 1

Ports:
clk_100MHz  in  1  system clock; the only clock
reset  in  1  synchronous, active-high
tick_en  in  1  1 = game_tick generation runs; 0 = paused
p_tick  out  1  one-cycle pixel enable, high once every CLK_DIV cycles
x  out  10  horizontal count, 0..H_TOTAL-1
y  out  10  vertical count, 0..V_TOTAL-1
video_on  out  1  high when x < H_DISPLAY and y < V_DISPLAY
hsync  out  1  active-low horizontal sync
vsync  out  1  active-low vertical sync
game_tick  out  1  one-cycle pulse every TICK_FRAMES frames

Behaviour:
- Definitions: H_TOTAL = sum of the H parameters (800). V_TOTAL = sum of the V parameters (525). Both must be 1024 or less so they fit the 10-bit counters.
- Only one clock and one reset exist. All state changes on the rising edge of clk_100MHz. Reset is synchronous and active-high; it has priority over everything else, including a reset asserted mid-frame.
- Reset values: div = 0, x = 0, y = 0, frame_cnt = 0, p_tick = 0, game_tick = 0, video_on = 1, hsync = 1, vsync = 1.
- Pixel divider:
  - div counts 0..CLK_DIV-1 and wraps.
  - p_tick is registered. It is high in the cycle after div reaches CLK_DIV-1.
  - After reset is released, the first p_tick comes CLK_DIV cycles later.
- Counters advance only in cycles where p_tick = 1:
  - x increments. At H_TOTAL-1, x wraps to 0 and y increments.
  - At (x = H_TOTAL-1, y = V_TOTAL-1), both wrap to 0. This is the frame wrap.
- hsync, vsync and video_on are registered. They are computed from the next x/y values so they are always aligned with the current x/y:
  - hsync = 0 when H_DISPLAY+H_FRONT <= x < H_DISPLAY+H_FRONT+H_SYNC (656..751).
  - vsync = 0 when V_DISPLAY+V_FRONT <= y < V_DISPLAY+V_FRONT+V_SYNC (490..491).
- frame_cnt (width $clog2(TICK_FRAMES)+1) with tick_en = 1:
  - On each frame wrap: if frame_cnt = TICK_FRAMES-1, frame_cnt returns to 0 and game_tick pulses high for exactly one clk_100MHz cycle, the same cycle that x/y become (0,0). Otherwise frame_cnt increments.
- tick_en = 0: frame_cnt is cleared to 0 and game_tick is held at 0. The raster keeps running.
- tick_en rising: counting restarts from 0. The first game_tick comes on the TICK_FRAMES-th frame wrap after the rise.
- When tick_en changes in the same cycle as a frame wrap, the new value of tick_en governs that wrap.
- Timing and rates:
  - Latency from counter to outputs is zero; x, y and the sync signals are coherent in every cycle.
  - Default rates: one frame = 420000 p_ticks = 1,680,000 clocks (59.52 Hz); game_tick is about 9.9 Hz.

Decomposition:
- Shared package vga_timing_pkg holds:
  - the default H/V porch, sync and display constants;
  - the H_TOTAL/V_TOTAL derivation;
  - COORD_W = 10.
  snake_game and this block both import it.
- One sub-module, pixel_tick_div, contains the CLK_DIV counter and the registered p_tick output.

Test Plan:
- Reset: hold reset for 3 cycles mid-frame (x = 300, y = 200) -> next cycle x = 0, y = 0, hsync = 1, vsync = 1, video_on = 1, p_tick = 0, game_tick = 0; first p_tick exactly 4 cycles after release.
- Horizontal timing (defaults): over one line -> 800 p_ticks; hsync low for x 656..751 (96 pixels); video_on falls at x = 640; x returns to 0 after 799 and y increments.
- Vertical timing: run one full frame -> vsync low only on y = 490 and 491; video_on is 0 for every y >= 480; frame wrap at (799,524) -> (0,0) after 1,680,000 clocks.
- Small-parameter frame and tick check: H 8/2/2/2, V 4/1/1/1, CLK_DIV = 2, TICK_FRAMES = 2, tick_en = 1 -> frame = 98 p_ticks; game_tick is a single-cycle pulse on every 2nd wrap (first at 392 clocks after release), coincident with x = 0, y = 0 and p_tick.
- Pause: same small parameters, drop tick_en after 1 frame, hold low for 3 frames, then raise -> no game_tick while low; the first game_tick comes 2 frame wraps after the rise.
- Simultaneous events: assert reset in the exact cycle of a frame wrap where game_tick would fire -> game_tick stays 0 and all outputs take their reset values.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants and helpers for the raster generator and snake_game.
// Totals are derived from the display/porch/sync spans; counters are COORD_W bits wide.
package vga_timing_pkg;

    localparam int COORD_W = 10;

    localparam int DEF_H_DISPLAY   = 640;
    localparam int DEF_H_FRONT     = 16;
    localparam int DEF_H_SYNC      = 96;
    localparam int DEF_H_BACK      = 48;
    localparam int DEF_V_DISPLAY   = 480;
    localparam int DEF_V_FRONT     = 10;
    localparam int DEF_V_SYNC      = 2;
    localparam int DEF_V_BACK      = 33;
    localparam int DEF_CLK_DIV     = 4;
    localparam int DEF_TICK_FRAMES = 6;

    // Line or frame length from its four spans (800 pixels / 525 lines at the defaults).
    function automatic int span_total(input int disp, input int front, input int sync, input int back);
        return disp + front + sync + back;
    endfunction

    function automatic logic in_range(input logic [COORD_W-1:0] v, input int lo, input int hi);
        return (int'(v) >= lo) && (int'(v) < hi);
    endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Divides the system clock down to a one-cycle pixel enable every CLK_DIV cycles.
// p_tick_o is registered; tick_next_o marks the cycle just before it, so callers can update alongside it.
module pixel_tick_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_next_o,
    output logic p_tick_o
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             p_tick_q;

    assign tick_next_o = (div_q == DIV_LAST);
    assign div_d       = tick_next_o ? '0 : div_q + DIV_W'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q    <= '0;
            p_tick_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            p_tick_q <= tick_next_o;
        end
    end

    assign p_tick_o = p_tick_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: pixel enable, x/y scan counters, active-low syncs, video_on and game_tick.
// x/y, syncs and video_on update on the same edge as p_tick; game_tick lands with the (0,0) frame wrap.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY   = DEF_H_DISPLAY,
    parameter int H_FRONT     = DEF_H_FRONT,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BACK      = DEF_H_BACK,
    parameter int V_DISPLAY   = DEF_V_DISPLAY,
    parameter int V_FRONT     = DEF_V_FRONT,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BACK      = DEF_V_BACK,
    parameter int CLK_DIV     = DEF_CLK_DIV,
    parameter int TICK_FRAMES = DEF_TICK_FRAMES
) (
    input  logic               clk_100MHz,
    input  logic               reset,
    input  logic               tick_en,
    output logic               p_tick,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               video_on,
    output logic               hsync,
    output logic               vsync,
    output logic               game_tick
);

    localparam int H_TOTAL = span_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = span_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
    localparam int HS_BEG  = H_DISPLAY + H_FRONT;
    localparam int HS_END  = HS_BEG + H_SYNC;
    localparam int VS_BEG  = V_DISPLAY + V_FRONT;
    localparam int VS_END  = VS_BEG + V_SYNC;
    localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);
    localparam int FC_W = $clog2(TICK_FRAMES) + 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(TICK_FRAMES - 1);

    logic               adv;
    logic               frame_wrap;
    logic [COORD_W-1:0] x_q;
    logic [COORD_W-1:0] x_d;
    logic [COORD_W-1:0] y_q;
    logic [COORD_W-1:0] y_d;
    logic [FC_W-1:0]    frame_cnt_q;
    logic [FC_W-1:0]    frame_cnt_d;
    logic               game_tick_q;
    logic               game_tick_d;
    logic               video_on_q;
    logic               hsync_q;
    logic               vsync_q;

    // adv is the cycle before p_tick, so x/y change on the very edge that raises p_tick.
    pixel_tick_div #(
        .CLK_DIV(CLK_DIV)
    ) u_pixel_tick_div (
        .clk_i      (clk_100MHz),
        .rst_i      (reset),
        .tick_next_o(adv),
        .p_tick_o   (p_tick)
    );

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (adv) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + COORD_W'(1);
            end else begin
                x_d = x_q + COORD_W'(1);
            end
        end
    end

    assign frame_wrap = adv && (x_q == H_LAST) && (y_q == V_LAST);

    // tick_en is looked at in the same cycle as the wrap, so a pause or resume governs that wrap.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        game_tick_d = 1'b0;
        if (!tick_en) begin
            frame_cnt_d = '0;
        end else if (frame_wrap) begin
            if (frame_cnt_q == FC_LAST) begin
                frame_cnt_d = '0;
                game_tick_d = 1'b1;
            end else begin
                frame_cnt_d = frame_cnt_q + FC_W'(1);
            end
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            x_q         <= '0;
            y_q         <= '0;
            frame_cnt_q <= '0;
            game_tick_q <= 1'b0;
            video_on_q  <= 1'b1;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            frame_cnt_q <= frame_cnt_d;
            game_tick_q <= game_tick_d;
            video_on_q  <= in_range(x_d, 0, H_DISPLAY) && in_range(y_d, 0, V_DISPLAY);
            hsync_q     <= !in_range(x_d, HS_BEG, HS_END);
            vsync_q     <= !in_range(y_d, VS_BEG, VS_END);
        end
    end

    assign x         = x_q;
    assign y         = y_q;
    assign video_on  = video_on_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign game_tick = game_tick_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default, tiny raster, tiny-H/default-V) against an arithmetic raster model.
// The model derives every output from the cycle count since reset and the wrap count since tick_en last rose.
module tb_vga_timing_gen;

    logic            clk;
    logic [2:0]      rst;
    logic [2:0]      en;
    logic [2:0]      pt;
    logic [2:0]      gt;
    logic [2:0]      vo;
    logic [2:0]      hs;
    logic [2:0]      vs;
    logic [2:0][9:0] xx;
    logic [2:0][9:0] yy;

    int errors = 0;
    int checks = 0;

    int HD  [3] = '{640, 8, 8};
    int HF  [3] = '{16, 2, 2};
    int HSW [3] = '{96, 2, 2};
    int HB  [3] = '{48, 2, 2};
    int VD  [3] = '{480, 4, 480};
    int VF  [3] = '{10, 1, 10};
    int VSW [3] = '{2, 1, 2};
    int VB  [3] = '{33, 1, 33};
    int D   [3] = '{4, 2, 2};
    int TF  [3] = '{6, 2, 1};
    string tags [3] = '{"model_dflt", "model_small", "model_tallv"};

    int   n  [3];
    int   ec [3];
    logic gm [3];
    bit   mv [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vga_timing_gen u_dflt (
        .clk_100MHz(clk), .reset(rst[0]), .tick_en(en[0]), .p_tick(pt[0]),
        .x(xx[0]), .y(yy[0]), .video_on(vo[0]), .hsync(hs[0]), .vsync(vs[0]), .game_tick(gt[0])
    );

    vga_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .CLK_DIV(2), .TICK_FRAMES(2)
    ) u_small (
        .clk_100MHz(clk), .reset(rst[1]), .tick_en(en[1]), .p_tick(pt[1]),
        .x(xx[1]), .y(yy[1]), .video_on(vo[1]), .hsync(hs[1]), .vsync(vs[1]), .game_tick(gt[1])
    );

    vga_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .CLK_DIV(2), .TICK_FRAMES(1)
    ) u_tallv (
        .clk_100MHz(clk), .reset(rst[2]), .tick_en(en[2]), .p_tick(pt[2]),
        .x(xx[2]), .y(yy[2]), .video_on(vo[2]), .hsync(hs[2]), .vsync(vs[2]), .game_tick(gt[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int ht(input int i);
        return HD[i] + HF[i] + HSW[i] + HB[i];
    endfunction

    function automatic int vt(input int i);
        return VD[i] + VF[i] + VSW[i] + VB[i];
    endfunction

    // A frame wrap happens on every (H_TOTAL*V_TOTAL)-th pixel step, each step being D clocks.
    function automatic bit is_wrap(input int i, input int cyc);
        return (cyc % D[i] == 0) && ((cyc / D[i]) % (ht(i) * vt(i)) == 0);
    endfunction

    function automatic int next_ec(input int i);
        if (!en[i]) return 0;
        if (is_wrap(i, n[i] + 1)) return ec[i] + 1;
        return ec[i];
    endfunction

    function automatic logic next_gm(input int i);
        return en[i] && is_wrap(i, n[i] + 1) && ((ec[i] + 1) % TF[i] == 0);
    endfunction

    function automatic logic [31:0] model_out(input int i);
        int   k;
        int   xe;
        int   ye;
        logic p;
        logic v;
        logic h;
        logic s;
        k  = n[i] / D[i];
        xe = k % ht(i);
        ye = (k / ht(i)) % vt(i);
        p  = (n[i] > 0) && (n[i] % D[i] == 0);
        v  = (xe < HD[i]) && (ye < VD[i]);
        h  = !((xe >= HD[i] + HF[i]) && (xe < HD[i] + HF[i] + HSW[i]));
        s  = !((ye >= VD[i] + VF[i]) && (ye < VD[i] + VF[i] + VSW[i]));
        return {7'b0, p, gm[i], v, h, s, ye[9:0], xe[9:0]};
    endfunction

    function automatic logic [31:0] got_vec(input int i);
        return {7'b0, pt[i], gt[i], vo[i], hs[i], vs[i], yy[i], xx[i]};
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst[i]) begin
                n[i]  <= 0;
                ec[i] <= 0;
                gm[i] <= 1'b0;
                mv[i] <= 1'b1;
            end else begin
                n[i]  <= n[i] + 1;
                ec[i] <= next_ec(i);
                gm[i] <= next_gm(i);
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++)
            if (mv[i]) check(tags[i], got_vec(i), model_out(i));
    end

    task automatic run_wraps(input int nw, output int seen, output int gts, output int first);
        int cyc;
        seen  = 0;
        gts   = 0;
        first = 0;
        cyc   = 0;
        while (seen < nw && cyc < nw * 200 + 50) begin
            @(negedge clk);
            cyc++;
            if (pt[1] && xx[1] == 10'd0 && yy[1] == 10'd0) seen++;
            if (gt[1]) begin
                gts++;
                if (first == 0) first = seen;
            end
        end
    endtask

    initial begin
        int cnt;
        int ptc;
        int hs_low;
        int hs_first;
        int hs_last;
        int vid_fall;
        int last_x;
        int wraps;
        int gts;
        int first_gt;
        int vs_lines;
        int vs_first;
        int vid_bad;

        rst = 3'b111;
        en  = 3'b111;
        repeat (3) @(negedge clk);

        // Default timing: first p_tick, reset mid-line, then one full line.
        rst[0] = 1'b0;
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (!pt[0] && cnt < 20);
        check("first_ptick_clks", cnt, 4);

        cnt = 0;
        while (xx[0] != 10'd300 && cnt < 2000) begin @(negedge clk); cnt++; end
        check("pre_reset_x", 32'(xx[0]), 300);
        rst[0] = 1'b1;
        @(negedge clk);
        check("rst_x", 32'(xx[0]), 0);
        check("rst_y", 32'(yy[0]), 0);
        check("rst_hsync", 32'(hs[0]), 1);
        check("rst_vsync", 32'(vs[0]), 1);
        check("rst_video_on", 32'(vo[0]), 1);
        check("rst_p_tick", 32'(pt[0]), 0);
        check("rst_game_tick", 32'(gt[0]), 0);
        repeat (2) @(negedge clk);
        rst[0] = 1'b0;
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (!pt[0] && cnt < 20);
        check("ptick_after_rst_clks", cnt, 4);

        ptc = 1; hs_low = 0; hs_first = -1; hs_last = -1; vid_fall = -1; last_x = -1; cnt = 0;
        while (!(xx[0] == 10'd0 && yy[0] == 10'd1) && cnt < 4000) begin
            last_x = int'(xx[0]);
            @(negedge clk);
            cnt++;
            if (pt[0]) begin
                ptc++;
                if (!hs[0]) begin
                    hs_low++;
                    if (hs_first < 0) hs_first = int'(xx[0]);
                    hs_last = int'(xx[0]);
                end
                if (!vo[0] && vid_fall < 0) vid_fall = int'(xx[0]);
            end
        end
        check("line_pticks", ptc, 800);
        check("hsync_low_px", hs_low, 96);
        check("hsync_first_x", hs_first, 656);
        check("hsync_last_x", hs_last, 751);
        check("video_fall_x", vid_fall, 640);
        check("x_before_wrap", last_x, 799);
        check("y_after_line", 32'(yy[1 - 1]), 1);

        // Tiny raster: first game_tick, pause/resume, reset colliding with a ticking wrap.
        rst[1] = 1'b0;
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (!gt[1] && cnt < 1000);
        check("first_gtick_clks", cnt, 392);
        check("gtick_x", 32'(xx[1]), 0);
        check("gtick_y", 32'(yy[1]), 0);
        check("gtick_ptick", 32'(pt[1]), 1);
        @(negedge clk);
        check("gtick_width", 32'(gt[1]), 0);

        run_wraps(1, wraps, gts, first_gt);
        check("odd_frame_wraps", wraps, 1);
        check("odd_frame_gticks", gts, 0);
        en[1] = 1'b0;
        run_wraps(3, wraps, gts, first_gt);
        check("paused_wraps", wraps, 3);
        check("paused_gticks", gts, 0);
        en[1] = 1'b1;
        run_wraps(2, wraps, gts, first_gt);
        check("resume_wraps", wraps, 2);
        check("resume_gticks", gts, 1);
        check("resume_first_wrap", first_gt, 2);

        run_wraps(1, wraps, gts, first_gt);
        check("pre_collide_gticks", gts, 0);
        cnt = 0;
        while (!(pt[1] && xx[1] == 10'd13 && yy[1] == 10'd6) && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        check("pre_collide_x", 32'(xx[1]), 13);
        @(negedge clk);
        rst[1] = 1'b1;
        @(negedge clk);
        check("collide_flags", {27'b0, pt[1], gt[1], vo[1], hs[1], vs[1]}, 32'h07);
        check("collide_xy", {12'b0, yy[1], xx[1]}, 0);
        rst[1] = 1'b0;

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 299) == 0) en[1] = ~en[1];
            rst[1] = ($urandom_range(0, 799) == 0);
        end
        rst[1] = 1'b0;
        en[1]  = 1'b1;

        // Default vertical timing on a narrow raster, tick every frame.
        rst[2] = 1'b0;
        cnt = 0; vs_lines = 0; vs_first = -1; vid_bad = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (pt[2] && xx[2] == 10'd0 && !vs[2]) begin
                vs_lines++;
                if (vs_first < 0) vs_first = int'(yy[2]);
            end
            if (vo[2] && yy[2] >= 10'd480) vid_bad++;
        end while (!(pt[2] && xx[2] == 10'd0 && yy[2] == 10'd0) && cnt < 20000);
        check("frame_clks", cnt, 14700);
        check("vsync_lines", vs_lines, 2);
        check("vsync_first_y", vs_first, 490);
        check("video_off_rows", vid_bad, 0);
        check("tf1_gtick", 32'(gt[2]), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
